br_lite_local_ctrl: RTL

//  Local-port controller for one BrLiteRouter. Shares the router LOCAL input among NCLI on-tile clients

---
 rtl/br_lite_local_ctrl_pkg.sv | 20 ++
 rtl/br_lite_local_ctrl_rr_arbiter.sv | 26 ++
 rtl/br_lite_local_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/br_lite_local_ctrl_pkg.sv
// br_lite_local_ctrl_pkg: flit/service types and FSM states shared by the local-port controller
package br_lite_local_ctrl_pkg;
  localparam int BR_ID_W      = 8;
  localparam int BR_PAYLOAD_W = 32;
  typedef enum logic [1:0] {
    BR_SVC_ALL   = 2'd0,
    BR_SVC_TGT   = 2'd1,
    BR_SVC_CLEAR = 2'd2,
    BR_SVC_RSVD  = 2'd3
  } br_svc_t;
  typedef struct packed {
    br_svc_t                 service;
    logic [15:0]             source;
    logic [15:0]             target;
    logic [BR_ID_W-1:0]      id;
    logic [BR_PAYLOAD_W-1:0] payload;
  } br_data_t;
  typedef enum logic [1:0] {INJ_IDLE, INJ_REQ, INJ_ERR, INJ_REL} inj_st_e;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT} rx_st_e;
endpackage

// File: rtl/br_lite_local_ctrl_rr_arbiter.sv
// br_lite_rr_arbiter: combinational round-robin pick of the first requester at or after ptr
module br_lite_rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic         w_found;
  logic [W-1:0] w_k;
  always_comb begin
    w_found = 1'b0;
    w_k     = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      w_k = W'((int'(ptr) + i) % N);
      if (!w_found && req[w_k]) begin
        w_found = 1'b1;
        idx     = w_k;
      end
    end
    gnt = w_found ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/br_lite_local_ctrl.sv
// br_lite_local_ctrl: round-robin flit injection into the router LOCAL port plus a 1-entry delivery buffer
module br_lite_local_ctrl
  import br_lite_local_ctrl_pkg::*;
#(
  parameter logic [15:0] ADDRESS     = 16'h0000,
  parameter int          NCLI        = 4,
  parameter int          ACK_TIMEOUT = 1024
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NCLI-1:0]                    cli_req_i,
  input  br_svc_t [NCLI-1:0]                 cli_svc_i,
  input  logic [NCLI-1:0][15:0]              cli_target_i,
  input  logic [NCLI-1:0][BR_PAYLOAD_W-1:0]  cli_payload_i,
  output logic [NCLI-1:0]                    cli_gnt_o,
  output logic [NCLI-1:0]                    cli_err_o,
  output br_data_t                           inj_flit_o,
  output logic                               inj_req_o,
  input  logic                               inj_ack_i,
  input  logic                               local_busy_i,
  input  br_data_t                           rx_flit_i,
  input  logic                               rx_req_i,
  output logic                               rx_ack_o,
  output logic                               dlv_valid_o,
  output br_data_t                           dlv_flit_o,
  input  logic                               dlv_ready_i,
  output logic [15:0]                        stall_cnt_o
);
  localparam int IW = $clog2(NCLI);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  inj_st_e            r_inj_st, w_inj_nxt;
  rx_st_e             r_rx_st, w_rx_nxt;
  logic [IW-1:0]      r_ptr, r_idx, w_arb_idx;
  logic [NCLI-1:0]    w_arb_gnt, r_gnt, r_err;
  logic [BR_ID_W-1:0] r_id;
  logic [TW-1:0]      r_tmo;
  logic [15:0]        r_stall;
  br_data_t           r_flit, r_dlv_flit;
  logic               r_req, r_rx_ack, r_dlv_valid;
  logic               w_start, w_svc_ok, w_tmo, w_cap, w_acked;
  br_lite_rr_arbiter #(.N(NCLI), .W(IW)) u_arb (
    .req (cli_req_i),
    .ptr (r_ptr),
    .gnt (w_arb_gnt),
    .idx (w_arb_idx)
  );
  assign w_start  = r_inj_st == INJ_IDLE && |cli_req_i && !local_busy_i && !inj_ack_i;
  assign w_svc_ok = cli_svc_i[w_arb_idx] == BR_SVC_ALL || cli_svc_i[w_arb_idx] == BR_SVC_TGT;
  assign w_tmo    = r_tmo == TW'(ACK_TIMEOUT - 1);
  assign w_acked  = r_inj_st == INJ_REQ && inj_ack_i;
  assign w_cap    = r_rx_st == RX_IDLE && rx_req_i && !r_dlv_valid;
  always_comb begin
    w_inj_nxt = r_inj_st;
    case (r_inj_st)
      INJ_IDLE: w_inj_nxt = w_start ? (w_svc_ok ? INJ_REQ : INJ_ERR) : INJ_IDLE;
      INJ_REQ:  w_inj_nxt = inj_ack_i ? INJ_REL : (w_tmo ? INJ_ERR : INJ_REQ);
      INJ_ERR:  w_inj_nxt = INJ_REL;
      default:  w_inj_nxt = inj_ack_i ? INJ_REL : INJ_IDLE;
    endcase
    w_rx_nxt = r_rx_st == RX_IDLE ? (w_cap ? RX_ACK : RX_IDLE) :
               r_rx_st == RX_ACK  ? RX_WAIT : (rx_req_i ? RX_WAIT : RX_IDLE);
  end
  // outputs are registered from the transition being taken, so they line up with the new state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inj_st    <= INJ_IDLE;
      r_rx_st     <= RX_IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_id        <= '0;
      r_tmo       <= '0;
      r_stall     <= '0;
      r_flit      <= '0;
      r_req       <= 1'b0;
      r_gnt       <= '0;
      r_err       <= '0;
      r_rx_ack    <= 1'b0;
      r_dlv_valid <= 1'b0;
      r_dlv_flit  <= '0;
    end else begin
      r_inj_st <= w_inj_nxt;
      r_rx_st  <= w_rx_nxt;
      r_req    <= w_inj_nxt == INJ_REQ;
      r_gnt    <= w_acked ? NCLI'(1) << r_idx : '0;
      r_err    <= w_inj_nxt == INJ_ERR ? (r_inj_st == INJ_IDLE ? w_arb_gnt : NCLI'(1) << r_idx) : '0;
      if (w_start) begin
        r_idx  <= w_arb_idx;
        r_ptr  <= w_arb_idx == IW'(NCLI - 1) ? '0 : w_arb_idx + 1'b1;
        r_flit <= '{service: cli_svc_i[w_arb_idx], source: ADDRESS, target: cli_target_i[w_arb_idx],
                    id: r_id, payload: cli_payload_i[w_arb_idx]};
        r_tmo  <= '0;
      end
      if (w_acked) r_id <= r_id + 1'b1;
      if (r_inj_st == INJ_REQ && !inj_ack_i) begin
        r_tmo <= r_tmo + 1'b1;
        if (r_stall != '1) r_stall <= r_stall + 1'b1;
      end
      r_rx_ack    <= w_cap;
      r_dlv_valid <= w_cap | (r_dlv_valid & !dlv_ready_i);
      if (w_cap) r_dlv_flit <= rx_flit_i;
    end
  end
  assign cli_gnt_o   = r_gnt;
  assign cli_err_o   = r_err;
  assign inj_flit_o  = r_flit;
  assign inj_req_o   = r_req;
  assign rx_ack_o    = r_rx_ack;
  assign dlv_valid_o = r_dlv_valid;
  assign dlv_flit_o  = r_dlv_flit;
  assign stall_cnt_o = r_stall;
endmodule
